// File: rtl/xif_cpr_router.sv
// Routes CPU coprocessor-interface issue, commit and result traffic across NUM_CPR channels,
// tracking outstanding instructions in a small table and flagging protocol errors.
module xif_cpr_router #(
  parameter int NUM_CPR = 2,
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [ID_W-1:0]          issue_id_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [ID_W-1:0]          commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [ID_W-1:0]          result_id_o,
  output logic [31:0]              result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic [NUM_CPR-1:0]       cpr_issue_valid_o,
  input  logic [NUM_CPR-1:0]       cpr_issue_ready_i,
  input  logic [NUM_CPR-1:0]       cpr_issue_accept_i,
  input  logic [NUM_CPR-1:0]       cpr_issue_writeback_i,
  output logic [31:0]              cpr_instr_o,
  output logic [ID_W-1:0]          cpr_id_o,
  output logic [NUM_CPR-1:0]       cpr_commit_valid_o,
  output logic [ID_W-1:0]          cpr_commit_id_o,
  output logic                     cpr_commit_kill_o,
  input  logic [NUM_CPR-1:0]       cpr_result_valid_i,
  output logic [NUM_CPR-1:0]       cpr_result_ready_o,
  input  logic [NUM_CPR*ID_W-1:0]  cpr_result_id_i,
  input  logic [NUM_CPR*32-1:0]    cpr_result_data_i,
  input  logic [NUM_CPR*5-1:0]     cpr_result_rd_i,
  input  logic [NUM_CPR-1:0]       cpr_result_we_i,
  output logic                     error_o
);
  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1;
  // valid must not depend on ready, and the payload is held stable while valid waits.

  localparam int PW = (NUM_CPR > 1) ? $clog2(NUM_CPR) : 1;
  localparam int EW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PROBE, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   k_q, k_d;
  logic            acc_q, acc_d, wb_q, wb_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            alloc;

  logic [DEPTH-1:0] ent_valid, ent_wb, ent_cmt;
  logic [ID_W-1:0]  ent_id    [DEPTH];
  logic [PW-1:0]    ent_owner [DEPTH];
  logic             full;

  logic [PW-1:0]   ptr_q, lock_g_q, grant;
  logic            lock_q, gvalid;
  logic [ID_W-1:0] res_id;
  logic            res_hit, drop_kill, res_err, res_fire, res_free;
  logic [EW-1:0]   res_idx, free_idx, cm_idx;
  logic            cm_hit;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CPR) s = s - NUM_CPR;
    return PW'(s);
  endfunction

  assign full        = &ent_valid;
  assign cpr_instr_o = issue_instr_i;
  assign cpr_id_o    = issue_id_i;

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    acc_d             = acc_q;
    wb_d              = wb_q;
    id_d              = id_q;
    alloc             = 1'b0;
    issue_ready_o     = 1'b0;
    issue_accept_o    = 1'b0;
    issue_writeback_o = 1'b0;
    cpr_issue_valid_o = '0;
    case (state_q)
      IDLE: begin
        if (issue_valid_i && !full) begin
          state_d = PROBE;
          k_d     = '0;
          id_d    = issue_id_i;
          acc_d   = 1'b0;
          wb_d    = 1'b0;
        end
      end
      PROBE: begin
        cpr_issue_valid_o[k_q] = 1'b1;
        if (cpr_issue_ready_i[k_q]) begin
          acc_d = cpr_issue_accept_i[k_q];
          wb_d  = cpr_issue_accept_i[k_q] & cpr_issue_writeback_i[k_q];
          if (cpr_issue_accept_i[k_q] || k_q == PW'(NUM_CPR - 1)) state_d = RESP;
          else k_d = k_q + PW'(1);
        end
      end
      RESP: begin
        issue_ready_o     = 1'b1;
        issue_accept_o    = acc_q;
        issue_writeback_o = wb_q;
        alloc             = acc_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      issue_ready_o     = 1'b0;
      issue_accept_o    = 1'b0;
      issue_writeback_o = 1'b0;
      cpr_issue_valid_o = '0;
      alloc             = 1'b0;
    end
  end

  // Round-robin grant; a stalled grant stays locked so the CPU sees a stable payload.
  always_comb begin
    grant  = ptr_q;
    gvalid = 1'b0;
    if (lock_q) begin
      grant  = lock_g_q;
      gvalid = cpr_result_valid_i[lock_g_q];
    end else begin
      for (int i = NUM_CPR - 1; i >= 0; i--) begin
        if (cpr_result_valid_i[rr_idx(ptr_q, i)]) begin
          grant  = rr_idx(ptr_q, i);
          gvalid = 1'b1;
        end
      end
    end
  end

  assign res_id        = cpr_result_id_i[grant*ID_W +: ID_W];
  assign result_id_o   = res_id;
  assign result_data_o = cpr_result_data_i[grant*32 +: 32];
  assign result_rd_o   = cpr_result_rd_i[grant*5 +: 5];
  assign result_we_o   = cpr_result_we_i[grant];

  always_comb begin
    free_idx = '0;
    cm_hit   = 1'b0;
    cm_idx   = '0;
    res_hit  = 1'b0;
    res_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = EW'(i);
      if (ent_valid[i] && ent_id[i] == commit_id_i) begin
        cm_hit = 1'b1;
        cm_idx = EW'(i);
      end
      if (ent_valid[i] && ent_cmt[i] && ent_owner[i] == grant && ent_id[i] == res_id) begin
        res_hit = 1'b1;
        res_idx = EW'(i);
      end
    end
  end

  always_comb begin
    drop_kill          = commit_valid_i && commit_kill_i && commit_id_i == res_id;
    result_valid_o     = gvalid && res_hit && !drop_kill;
    res_err            = gvalid && !res_hit && !drop_kill;
    cpr_result_ready_o = '0;
    if (gvalid) cpr_result_ready_o[grant] = result_valid_o ? result_ready_i : 1'b1;
    if (rst_i) begin
      result_valid_o     = 1'b0;
      res_err            = 1'b0;
      cpr_result_ready_o = '0;
    end
    res_fire = gvalid && cpr_result_ready_o[grant];
    res_free = result_valid_o && result_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= IDLE;
      k_q                <= '0;
      acc_q              <= 1'b0;
      wb_q               <= 1'b0;
      id_q               <= '0;
      ent_valid          <= '0;
      ent_wb             <= '0;
      ent_cmt            <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_id[i]    <= '0;
        ent_owner[i] <= '0;
      end
      ptr_q              <= '0;
      lock_q             <= 1'b0;
      lock_g_q           <= '0;
      cpr_commit_valid_o <= '0;
      cpr_commit_id_o    <= '0;
      cpr_commit_kill_o  <= 1'b0;
      error_o            <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
      id_q    <= id_d;
      if (alloc) begin
        ent_valid[free_idx] <= 1'b1;
        ent_id[free_idx]    <= id_q;
        ent_owner[free_idx] <= k_q;
        ent_wb[free_idx]    <= wb_q;
        ent_cmt[free_idx]   <= 1'b0;
      end
      cpr_commit_valid_o <= '0;
      if (commit_valid_i) begin
        if (cm_hit) begin
          cpr_commit_valid_o <= NUM_CPR'(1) << ent_owner[cm_idx];
          cpr_commit_id_o    <= commit_id_i;
          cpr_commit_kill_o  <= commit_kill_i;
          if (commit_kill_i || !ent_wb[cm_idx]) ent_valid[cm_idx] <= 1'b0;
          else ent_cmt[cm_idx] <= 1'b1;
        end else begin
          error_o <= 1'b1;
        end
      end
      if (res_free) ent_valid[res_idx] <= 1'b0;
      if (res_err) error_o <= 1'b1;
      if (res_fire) ptr_q <= rr_idx(grant, 1);
      lock_q   <= result_valid_o && !result_ready_i;
      lock_g_q <= grant;
    end
  end
endmodule

// File: tb/tb_xif_cpr_router.sv
// Directed bench for xif_cpr_router: a per-id transaction model feeds expected queues
// that one negedge compare process drains, plus literal timing and data pins.
module tb_xif_cpr_router;
  localparam int NUM_CPR = 2;
  localparam int ID_W    = 4;
  localparam int DEPTH   = 4;
  localparam int CW      = NUM_CPR + ID_W + 1;
  localparam int RW      = ID_W + 32 + 5 + 1;

  logic clk = 1'b0;
  logic rst_i;
  logic issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0] issue_instr_i;
  logic [ID_W-1:0] issue_id_i;
  logic commit_valid_i, commit_kill_i;
  logic [ID_W-1:0] commit_id_i;
  logic result_valid_o, result_ready_i, result_we_o;
  logic [ID_W-1:0] result_id_o;
  logic [31:0] result_data_o;
  logic [4:0] result_rd_o;
  logic [NUM_CPR-1:0] cpr_issue_valid_o, cpr_issue_ready_i, cpr_issue_accept_i, cpr_issue_writeback_i;
  logic [31:0] cpr_instr_o;
  logic [ID_W-1:0] cpr_id_o, cpr_commit_id_o;
  logic [NUM_CPR-1:0] cpr_commit_valid_o;
  logic cpr_commit_kill_o;
  logic [NUM_CPR-1:0] cpr_result_valid_i, cpr_result_ready_o, cpr_result_we_i;
  logic [NUM_CPR*ID_W-1:0] cpr_result_id_i;
  logic [NUM_CPR*32-1:0] cpr_result_data_i;
  logic [NUM_CPR*5-1:0] cpr_result_rd_i;
  logic error_o;

  xif_cpr_router #(.NUM_CPR(NUM_CPR), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .cpr_issue_valid_o(cpr_issue_valid_o), .cpr_issue_ready_i(cpr_issue_ready_i),
    .cpr_issue_accept_i(cpr_issue_accept_i), .cpr_issue_writeback_i(cpr_issue_writeback_i),
    .cpr_instr_o(cpr_instr_o), .cpr_id_o(cpr_id_o),
    .cpr_commit_valid_o(cpr_commit_valid_o), .cpr_commit_id_o(cpr_commit_id_o),
    .cpr_commit_kill_o(cpr_commit_kill_o),
    .cpr_result_valid_i(cpr_result_valid_i), .cpr_result_ready_o(cpr_result_ready_o),
    .cpr_result_id_i(cpr_result_id_i), .cpr_result_data_i(cpr_result_data_i),
    .cpr_result_rd_i(cpr_result_rd_i), .cpr_result_we_i(cpr_result_we_i), .error_o(error_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: outstanding instructions keyed by id
  bit m_live [16];
  bit m_cmt  [16];
  bit m_wb   [16];
  int m_owner[16];
  bit m_err;
  int m_ptr;

  logic [1:0]    iss_q[$];
  logic [CW-1:0] cmt_q[$];
  logic [RW-1:0] res_q[$];

  logic [ID_W-1:0] p_id;
  bit p_acc, p_wb;
  int p_owner, p_lat, last_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_live[i] = 0; m_cmt[i] = 0; m_wb[i] = 0; m_owner[i] = 0;
    end
    m_err = 0;
    m_ptr = 0;
    iss_q.delete(); cmt_q.delete(); res_q.delete();
  endtask

  // scoreboard: every meaningful output cycle is checked against the model queues
  logic [1:0]    iss_e;
  logic [CW-1:0] cmt_e;
  logic [RW-1:0] res_e;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (issue_ready_o) begin
        chk("issue_expected", 64'(iss_q.size() != 0), 1);
        if (iss_q.size() != 0) begin
          iss_e = iss_q.pop_front();
          chk("issue_resp", {issue_accept_o, issue_writeback_o}, iss_e);
        end
      end
      if (cpr_commit_valid_o != '0) begin
        chk("commit_expected", 64'(cmt_q.size() != 0), 1);
        if (cmt_q.size() != 0) begin
          cmt_e = cmt_q.pop_front();
          chk("commit_out", {cpr_commit_valid_o, cpr_commit_id_o, cpr_commit_kill_o}, cmt_e);
        end
      end
      if (result_valid_o && result_ready_i) begin
        chk("result_expected", 64'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          res_e = res_q.pop_front();
          chk("result_out", {result_id_o, result_data_o, result_rd_o, result_we_o}, res_e);
        end
      end
      chk("error_flag", error_o, m_err);
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic issue_start(input logic [ID_W-1:0] id, input logic [NUM_CPR-1:0] acc_mask,
                             input logic [NUM_CPR-1:0] wb_mask);
    p_id = id; p_acc = 0; p_owner = 0;
    for (int c = NUM_CPR - 1; c >= 0; c--) if (acc_mask[c]) begin p_acc = 1; p_owner = c; end
    p_wb  = p_acc && wb_mask[p_owner];
    p_lat = p_acc ? 2 + p_owner : 1 + NUM_CPR;
    iss_q.push_back({p_acc, p_wb});
    issue_id_i            = id;
    issue_instr_i         = 32'hA5A5_0000 | 32'(id);
    cpr_issue_ready_i     = '1;
    cpr_issue_accept_i    = acc_mask;
    cpr_issue_writeback_i = wb_mask;
    issue_valid_i         = 1'b1;
  endtask

  task automatic issue_wait(input bit chk_lat);
    bit seen;
    seen = 0;
    last_lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (chk_lat && n >= 1 && n < p_lat) begin
        chk("probe_onehot", cpr_issue_valid_o, 64'(1 << (n - 1)));
        chk("probe_payload", {cpr_instr_o, cpr_id_o}, {32'hA5A5_0000 | 32'(p_id), p_id});
      end
      if (issue_ready_o) begin seen = 1; last_lat = n; break; end
    end
    chk("issue_seen", seen, 1);
    if (chk_lat) chk("issue_latency", last_lat, p_lat);
    @(posedge clk);
    if (p_acc) begin
      m_live[p_id] = 1; m_cmt[p_id] = 0; m_wb[p_id] = p_wb; m_owner[p_id] = p_owner;
    end
    #1;
    issue_valid_i = 1'b0;
    cpr_issue_ready_i = '0;
  endtask

  task automatic do_commit(input logic [ID_W-1:0] id, input bit kill);
    bit hit;
    logic [NUM_CPR-1:0] ev;
    hit = m_live[id];
    ev = '0;
    if (hit) ev[m_owner[id]] = 1'b1;
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    @(posedge clk);
    if (hit) begin
      cmt_q.push_back({ev, id, kill});
      if (kill || !m_wb[id]) m_live[id] = 0;
      else m_cmt[id] = 1;
    end else m_err = 1;
    #1;
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    @(negedge clk);
    chk("commit_fanout", cpr_commit_valid_o, ev);
    @(posedge clk); #1;
  endtask

  task automatic drive_result(input int ch, input logic [ID_W-1:0] id, input logic [31:0] data,
                              input logic [4:0] rd, input bit we);
    cpr_result_valid_i[ch]             = 1'b1;
    cpr_result_id_i[ch*ID_W +: ID_W]   = id;
    cpr_result_data_i[ch*32 +: 32]     = data;
    cpr_result_rd_i[ch*5 +: 5]         = rd;
    cpr_result_we_i[ch]                = we;
  endtask

  task automatic do_result(input int ch, input logic [ID_W-1:0] id, input logic [31:0] data,
                           input logic [4:0] rd, input bit we);
    bit good, seen;
    good = m_live[id] && m_cmt[id] && m_owner[id] == ch;
    if (good) res_q.push_back({id, data, rd, we});
    drive_result(ch, id, data, rd, we);
    result_ready_i = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cpr_result_ready_o[ch]) begin seen = 1; break; end
    end
    chk("result_consumed", seen, 1);
    chk("result_valid_gate", result_valid_o, good);
    if (good) chk("result_data", result_data_o, data);
    @(posedge clk);
    if (good) m_live[id] = 0; else m_err = 1;
    m_ptr = (ch + 1) % NUM_CPR;
    #1;
    cpr_result_valid_i[ch] = 1'b0;
    result_ready_i = 1'b0;
  endtask

  initial begin
    model_clear();
    rst_i = 1'b1;
    issue_valid_i = 0; issue_instr_i = '0; issue_id_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
    result_ready_i = 0;
    cpr_issue_ready_i = '0; cpr_issue_accept_i = '0; cpr_issue_writeback_i = '0;
    cpr_result_valid_i = '0; cpr_result_id_i = '0; cpr_result_data_i = '0;
    cpr_result_rd_i = '0; cpr_result_we_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_probe", cpr_issue_valid_o, 0);
    chk("rst_commit", cpr_commit_valid_o, 0);
    chk("rst_result", {result_valid_o, cpr_result_ready_o}, 0);
    chk("rst_error", error_o, 0);
    @(posedge clk); #1;

    // ch0 rejects, ch1 accepts with writeback
    issue_start(4'd3, 2'b10, 2'b10);
    issue_wait(1);
    chk("lat_ch1_accept", last_lat, 3);
    // minimum latency: ch0 accepts at once
    issue_start(4'd5, 2'b01, 2'b00);
    issue_wait(1);
    chk("lat_min", last_lat, 2);
    // both reject: reply with accept=0 writeback=0, nothing allocated
    issue_start(4'd9, 2'b00, 2'b11);
    issue_wait(1);
    chk("lat_reject", last_lat, 3);

    do_commit(4'd3, 0);
    do_commit(4'd5, 0);
    do_result(1, 4'd3, 32'hDEADBEEF, 5'd7, 1'b1);

    // fill the table, then a fifth issue must wait for a free slot
    issue_start(4'd10, 2'b01, 2'b01); issue_wait(1);
    issue_start(4'd11, 2'b10, 2'b10); issue_wait(1);
    issue_start(4'd12, 2'b01, 2'b01); issue_wait(1);
    issue_start(4'd13, 2'b10, 2'b00); issue_wait(1);
    issue_start(4'd14, 2'b01, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_hold", issue_ready_o, 0);
      @(posedge clk); #1;
    end
    do_commit(4'd13, 0);
    issue_wait(0);

    // two pending results with the CPU stalling two cycles
    do_commit(4'd10, 0);
    do_commit(4'd11, 0);
    chk("rr_ptr_model", m_ptr, 0);
    res_q.push_back({4'd10, 32'h1111_0000, 5'd3, 1'b1});
    res_q.push_back({4'd11, 32'h2222_0001, 5'd4, 1'b0});
    drive_result(0, 4'd10, 32'h1111_0000, 5'd3, 1'b1);
    drive_result(1, 4'd11, 32'h2222_0001, 5'd4, 1'b0);
    result_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_valid", result_valid_o, 1);
      chk("stall_payload", {result_id_o, result_data_o}, {4'd10, 32'h1111_0000});
      chk("stall_ready", cpr_result_ready_o, 2'b00);
      @(posedge clk); #1;
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("rr_first_ready", cpr_result_ready_o, 2'b01);
    @(posedge clk);
    m_live[10] = 0;
    #1 cpr_result_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("rr_second_id", result_id_o, 4'd11);
    chk("rr_second_ready", cpr_result_ready_o, 2'b10);
    @(posedge clk);
    m_live[11] = 0; m_ptr = 0;
    #1 cpr_result_valid_i = '0; result_ready_i = 1'b0;

    // kill and result for the same id in one cycle: kill wins, no error
    do_commit(4'd12, 0);
    commit_valid_i = 1'b1; commit_id_i = 4'd12; commit_kill_i = 1'b1;
    drive_result(0, 4'd12, 32'h0BAD_0BAD, 5'd1, 1'b1);
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("kill_drop_valid", result_valid_o, 0);
    chk("kill_drop_ready", cpr_result_ready_o, 2'b01);
    @(posedge clk);
    cmt_q.push_back({2'b01, 4'd12, 1'b1});
    m_live[12] = 0; m_ptr = 1;
    #1 commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    cpr_result_valid_i = '0; result_ready_i = 1'b0;
    @(negedge clk);
    chk("kill_fanout", {cpr_commit_valid_o, cpr_commit_kill_o}, 3'b011);
    @(posedge clk); #1;

    // unknown commit id: sticky error, no fan-out
    do_commit(4'd7, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset while probing a channel that never answers
    issue_start(4'd15, 2'b01, 2'b01);
    cpr_issue_ready_i = '0;
    iss_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("probe_before_rst", cpr_issue_valid_o, 2'b01);
    @(posedge clk); #1;
    rst_i = 1'b1; issue_valid_i = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_mid_probe_ready", issue_ready_o, 0);
    chk("rst_mid_probe_valid", cpr_issue_valid_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {issue_ready_o, cpr_issue_valid_o, cpr_commit_valid_o, result_valid_o}, 0);
      chk("post_rst_error", error_o, 0);
      @(posedge clk); #1;
    end

    // after reset: fresh issue, a wrong-owner result, then the right one
    issue_start(4'd1, 2'b01, 2'b01);
    issue_wait(1);
    chk("lat_after_rst", last_lat, 2);
    do_commit(4'd1, 0);
    do_result(1, 4'd1, 32'h1234_5678, 5'd2, 1'b1);
    chk("bad_owner_error", error_o, 1);
    do_result(0, 4'd1, 32'hCAFE_F00D, 5'd9, 1'b1);

    repeat (2) @(posedge clk);
    chk("issue_q_drained", iss_q.size(), 0);
    chk("commit_q_drained", cmt_q.size(), 0);
    chk("result_q_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/xif_cpr_router.md
XIF_CPR_ROUTER -- requirements
Module: xif_cpr_router

Interface
REQ-001 SHALL have parameter NUM_CPR, default 2, number of coprocessor channels (1..4).
REQ-002 SHALL have parameter ID_W, default 4, instruction ID width.
REQ-003 SHALL have parameter DEPTH, default 4, outstanding-instruction table entries (2..8).
REQ-004 SHALL have ports: one clock; reset is synchronous and active-high: clk_i in 1 clock; rst_i in 1 sync active-high reset.
REQ-005 SHALL have CPU issue ports: issue_valid_i in 1; issue_ready_o out 1; issue_instr_i in 32; issue_id_i in ID_W; issue_accept_o out 1; issue_writeback_o out 1.
REQ-006 SHALL have CPU commit ports: commit_valid_i in 1; commit_id_i in ID_W; commit_kill_i in 1.
REQ-007 SHALL have CPU result ports: result_valid_o out 1; result_ready_i in 1; result_id_o out ID_W; result_data_o out 32; result_rd_o out 5; result_we_o out 1.
REQ-008 SHALL have per-channel ports, packed: cpr_issue_valid_o out NUM_CPR; cpr_issue_ready_i in NUM_CPR; cpr_issue_accept_i in NUM_CPR; cpr_issue_writeback_i in NUM_CPR; cpr_instr_o out 32 (shared); cpr_id_o out ID_W (shared).
REQ-009 SHALL have commit fan-out ports: cpr_commit_valid_o out NUM_CPR; cpr_commit_id_o out ID_W; cpr_commit_kill_o out 1.
REQ-010 SHALL have result ports: cpr_result_valid_i in NUM_CPR; cpr_result_ready_o out NUM_CPR; cpr_result_id_i in NUM_CPR*ID_W; cpr_result_data_i in NUM_CPR*32; cpr_result_rd_i in NUM_CPR*5; cpr_result_we_i in NUM_CPR; error_o out 1 sticky protocol error.

Function
REQ-011 Issue FSM SHALL have states IDLE, PROBE, RESP.
REQ-012 IDLE->PROBE with probe index k=0 when issue_valid_i and table not full; full holds issue_ready_o=0 in IDLE.
REQ-013 PROBE: cpr_issue_valid_o[k]=1 only; cpr_instr_o/cpr_id_o = CPU payload; on cpr_issue_ready_i[k], latch accept/writeback; go RESP if accept or k==NUM_CPR-1, else k+1 next cycle.
REQ-014 RESP: issue_ready_o=1 for exactly one cycle with latched accept/writeback (both 0 if all channels rejected); return IDLE.
REQ-015 Minimum issue latency: channel 0 ready at first PROBE cycle -> issue_ready_o two cycles after IDLE sampled issue_valid_i.
REQ-016 On accept in RESP, SHALL allocate lowest free entry {id, owner=k, wb, committed=0}.
REQ-017 Commit SHALL be registered, 1-cycle: matching entry -> cpr_commit_valid_o[owner]=1, cpr_commit_id_o, cpr_commit_kill_o.
REQ-018 Kill SHALL free entry; commit of wb=0 entry SHALL free it; wb=1 entry set committed.
REQ-019 Commit id with no valid entry SHALL produce no fan-out and set error_o.
REQ-020 Result arbiter SHALL be round-robin over cpr_result_valid_i, starting at pointer (reset 0); granted channel's fields pass combinationally to result_*_o; cpr_result_ready_o[g]=result_ready_i.
REQ-021 Grant SHALL lock while result_valid_o and not result_ready_i; on handshake pointer=g+1 mod NUM_CPR and matching entry freed.
REQ-022 Result whose id has no committed entry of that owner SHALL be consumed (ready=1) without result_valid_o and set error_o.
REQ-023 Same-cycle allocate and free SHALL both take effect; full evaluated from registered state.
REQ-024 Commit-kill and result for same id in same cycle: kill wins, result dropped, no error.

Reset
REQ-025 rst_i SHALL clear table, FSM=IDLE, k=0, RR pointer=0, error_o=0, all valid/ready outputs 0; mid-PROBE reset SHALL produce no issue_ready_o.

Verification
REQ-026 NUM_CPR=2, ch0 rejects, ch1 accepts wb=1 id=3 -> issue_ready_o in cycle 3, accept=1, entry owner=1.
REQ-027 Both reject -> issue_ready_o=1, accept=0, writeback=0, no allocation.
REQ-028 DEPTH=4 entries outstanding -> issue_ready_o stays 0 until commit/result frees one.
REQ-029 Commit id=3 kill=0 -> cpr_commit_valid_o=2'b10 next cycle; ch1 result id=3 data=0xDEADBEEF -> result_data_o=0xDEADBEEF, entry freed.
REQ-030 Both channels result valid, result_ready_i low 2 cycles -> ch0 held stable, then ch1 next.
REQ-031 Commit unknown id=7 -> no fan-out, error_o=1 until rst_i.
